// File: rtl/tlul_traffic_gen.sv
// TL-UL traffic generator: streams PutFullData and/or Get requests with a bounded
// number of outstanding requests and scores the responses, optionally comparing read-back data.
`timescale 1ns/1ps
module tlul_traffic_gen #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SRC_WIDTH  = 2,
    parameter int MAX_OUT    = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    clk_100,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [1:0]              cfg_mode,
    input  logic [ADDR_WIDTH-1:0]   cfg_base,
    input  logic [CNT_WIDTH-1:0]    cfg_num,
    input  logic [DATA_WIDTH-1:0]   cfg_seed,
    output logic                    a_valid,
    input  logic                    a_ready,
    output logic [2:0]              a_opcode,
    output logic [2:0]              a_param,
    output logic [2:0]              a_size,
    output logic [SRC_WIDTH-1:0]    a_source,
    output logic [ADDR_WIDTH-1:0]   a_address,
    output logic [DATA_WIDTH/8-1:0] a_mask,
    output logic [DATA_WIDTH-1:0]   a_data,
    input  logic                    d_valid,
    output logic                    d_ready,
    input  logic [2:0]              d_opcode,
    input  logic [SRC_WIDTH-1:0]    d_source,
    input  logic [DATA_WIDTH-1:0]   d_data,
    input  logic                    d_error,
    output logic                    busy,
    output logic                    done,
    output logic [7:0]              err_count,
    output logic [CNT_WIDTH-1:0]    issued
);
    localparam int MASK_WIDTH = DATA_WIDTH / 8;
    localparam int SIZE_LOG2  = $clog2(MASK_WIDTH);
    localparam int IDX_W      = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int OUT_W      = $clog2(MAX_OUT) + 1;

    localparam logic [2:0] OP_PUT  = 3'd0;
    localparam logic [2:0] OP_GET  = 3'd4;
    localparam logic [2:0] OP_ACK  = 3'd0;
    localparam logic [2:0] OP_ACKD = 3'd1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_WR_DRAIN,
        ST_RD,
        ST_RD_DRAIN,
        ST_FIN
    } state_t;

    state_t                state_q;
    logic [1:0]            mode_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [CNT_WIDTH-1:0]  num_q;
    logic [CNT_WIDTH-1:0]  idx_q;
    logic [CNT_WIDTH-1:0]  issued_q;
    logic [DATA_WIDTH-1:0] seed_q;
    logic [OUT_W-1:0]      out_q;
    logic [OUT_W-1:0]      out_d;
    logic [7:0]            err_q;
    logic [7:0]            err_d;
    logic                  done_q;

    logic [DATA_WIDTH-1:0] exp_mem [MAX_OUT];

    logic                  issue_phase;
    logic                  a_fire;
    logic                  d_fire;
    logic                  rsp_bad;
    logic [IDX_W-1:0]      src_idx;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_data;

    assign issue_phase = (state_q == ST_WR) || (state_q == ST_RD);
    assign a_valid     = issue_phase && (idx_q != num_q) && (out_q < OUT_W'(MAX_OUT));
    assign a_fire      = a_valid && a_ready;
    assign d_fire      = d_valid && d_ready;

    assign src_idx  = IDX_W'(idx_q % CNT_WIDTH'(MAX_OUT));
    assign req_addr = base_q + (ADDR_WIDTH'(idx_q) << SIZE_LOG2);
    assign req_data = seed_q + DATA_WIDTH'(idx_q);

    // Request fields only change when idx_q advances (on a fire), so they stay stable under back-pressure.
    assign a_opcode  = !a_valid ? 3'd0 : ((state_q == ST_RD) ? OP_GET : OP_PUT);
    assign a_param   = 3'd0;
    assign a_size    = a_valid ? 3'(SIZE_LOG2) : 3'd0;
    assign a_source  = a_valid ? SRC_WIDTH'(src_idx) : '0;
    assign a_address = a_valid ? req_addr : '0;
    assign a_mask    = a_valid ? '1 : '0;
    assign a_data    = a_valid ? req_data : '0;

    assign busy      = (state_q != ST_IDLE);
    assign d_ready   = busy;
    assign done      = done_q;
    assign err_count = err_q;
    assign issued    = issued_q;

    // Write and read phases never overlap: the drain states wait for every response.
    always_comb begin
        rsp_bad = d_error;
        case (state_q)
            ST_WR, ST_WR_DRAIN: begin
                if (d_opcode != OP_ACK) rsp_bad = 1'b1;
            end
            ST_RD, ST_RD_DRAIN: begin
                if (d_opcode != OP_ACKD) rsp_bad = 1'b1;
                if ((mode_q == 2'd2) && (d_data != exp_mem[d_source[IDX_W-1:0]])) rsp_bad = 1'b1;
            end
            default: rsp_bad = 1'b0;
        endcase
    end

    always_comb begin
        err_d = err_q;
        if (d_fire && rsp_bad && (err_q != 8'hFF)) err_d = err_q + 8'd1;
    end

    always_comb begin
        out_d = out_q;
        if (a_fire && !(d_fire && (out_q != '0)))      out_d = out_q + OUT_W'(1);
        else if (!a_fire && d_fire && (out_q != '0))   out_d = out_q - OUT_W'(1);
    end

    always_ff @(posedge clk_100) begin
        if (a_fire) exp_mem[src_idx] <= req_data;
    end

    always_ff @(posedge clk_100 or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            mode_q   <= 2'd0;
            base_q   <= '0;
            num_q    <= '0;
            seed_q   <= '0;
            idx_q    <= '0;
            issued_q <= '0;
            out_q    <= '0;
            err_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            out_q  <= out_d;
            err_q  <= err_d;
            if (a_fire) begin
                idx_q    <= idx_q + CNT_WIDTH'(1);
                issued_q <= issued_q + CNT_WIDTH'(1);
            end
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        mode_q   <= (cfg_mode == 2'd3) ? 2'd0 : cfg_mode;
                        base_q   <= cfg_base;
                        num_q    <= cfg_num;
                        seed_q   <= cfg_seed;
                        idx_q    <= '0;
                        issued_q <= '0;
                        err_q    <= '0;
                        if (cfg_num == '0)          state_q <= ST_FIN;
                        else if (cfg_mode == 2'd1)  state_q <= ST_RD;
                        else                        state_q <= ST_WR;
                    end
                end
                ST_WR: begin
                    if (a_fire && (idx_q == num_q - CNT_WIDTH'(1))) state_q <= ST_WR_DRAIN;
                end
                ST_WR_DRAIN: begin
                    if (out_q == '0) begin
                        if (mode_q == 2'd2) begin
                            state_q <= ST_RD;
                            idx_q   <= '0;
                        end else begin
                            state_q <= ST_FIN;
                        end
                    end
                end
                ST_RD: begin
                    if (a_fire && (idx_q == num_q - CNT_WIDTH'(1))) state_q <= ST_RD_DRAIN;
                end
                ST_RD_DRAIN: begin
                    if (out_q == '0) state_q <= ST_FIN;
                end
                ST_FIN: begin
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tlul_traffic_gen.sv
// Bench for tlul_traffic_gen: expected A requests are queued per run from the address/data
// rules, a monitor compares the DUT against the queue, and a randomized slave answers on D.
`timescale 1ns/1ps
module tb_tlul_traffic_gen;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 2;
    localparam int MO = 4;
    localparam int CW = 16;
    localparam int MW = DW / 8;

    logic          clk_100 = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    cfg_mode = '0;
    logic [AW-1:0] cfg_base = '0;
    logic [CW-1:0] cfg_num = '0;
    logic [DW-1:0] cfg_seed = '0;
    logic          a_valid;
    logic          a_ready = 1'b0;
    logic [2:0]    a_opcode, a_param, a_size;
    logic [SW-1:0] a_source;
    logic [AW-1:0] a_address;
    logic [MW-1:0] a_mask;
    logic [DW-1:0] a_data;
    logic          d_valid = 1'b0;
    logic          d_ready;
    logic [2:0]    d_opcode = '0;
    logic [SW-1:0] d_source = '0;
    logic [DW-1:0] d_data = '0;
    logic          d_error = 1'b0;
    logic          busy, done;
    logic [7:0]    err_count;
    logic [CW-1:0] issued;

    tlul_traffic_gen #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SRC_WIDTH(SW), .MAX_OUT(MO), .CNT_WIDTH(CW)
    ) dut (
        .clk_100(clk_100), .reset_n(reset_n), .start(start), .cfg_mode(cfg_mode),
        .cfg_base(cfg_base), .cfg_num(cfg_num), .cfg_seed(cfg_seed),
        .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
        .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
        .a_data(a_data), .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode),
        .d_source(d_source), .d_data(d_data), .d_error(d_error), .busy(busy), .done(done),
        .err_count(err_count), .issued(issued)
    );

    always #5 clk_100 = ~clk_100;

    typedef struct {
        logic [2:0]    op;
        logic [SW-1:0] src;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } req_t;

    req_t exp_q[$];
    req_t pend_q[$];
    req_t slv_a_req;
    bit   slv_a_fire = 0;
    bit   slv_d_fire = 0;
    bit   in_run = 0;
    int   checks = 0;
    int   errors = 0;
    int   fires = 0;
    int   model_out = 0;
    int   done_cnt = 0;
    int   run_dc0 = 0;
    int   run_mode = 0;
    int   exp_err = 0;
    int   rdy_prob = 100, rdy_limit = -1, d_prob = 100, err_prob = 0, corr_prob = 0, opbad_prob = 0;
    bit   hold_d = 0;
    bit   corrupt_src2 = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit chance(input int pct);
        return int'($urandom_range(99)) < pct;
    endfunction

    task automatic summary_and_finish();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    // Monitor: compares presented A requests with the expected queue and tracks outstanding count.
    initial begin : monitor
        req_t e;
        forever begin
            @(negedge clk_100);
            slv_a_fire = 0;
            slv_d_fire = 0;
            chk("busy", 64'(busy), 64'(in_run && !done));
            chk("d_ready", 64'(d_ready), 64'(in_run && !done));
            if (done) begin
                done_cnt++;
                in_run = 0;
            end
            if (a_valid) begin
                chk("a_outstanding_room", 64'(model_out < MO), 64'(1));
                if (exp_q.size() == 0) begin
                    chk("a_valid_unexpected", 64'(a_valid), 64'(0));
                end else begin
                    e = exp_q[0];
                    chk("a_opcode", 64'(a_opcode), 64'(e.op));
                    chk("a_param", 64'(a_param), 64'(0));
                    chk("a_size", 64'(a_size), 64'(2));
                    chk("a_mask", 64'(a_mask), 64'(4'hF));
                    chk("a_source", 64'(a_source), 64'(e.src));
                    chk("a_address", 64'(a_address), 64'(e.addr));
                    if (e.op == 3'd0) chk("a_data", 64'(a_data), 64'(e.data));
                    if (a_ready) begin
                        $display("A fire: op=%0d src=%0d addr=0x%08h data=0x%08h",
                                 a_opcode, a_source, a_address, a_data);
                        slv_a_req  = e;
                        slv_a_fire = 1;
                        void'(exp_q.pop_front());
                        fires++;
                        model_out++;
                    end
                end
            end
            if (d_valid && d_ready) begin
                slv_d_fire = 1;
                if (model_out > 0) model_out--;
            end
        end
    end

    // Slave: accepts requests, answers in order, and tallies which responses the DUT must flag.
    initial begin : slave
        req_t r;
        logic [DW-1:0] cd;
        bit bad;
        bit opbad;
        forever begin
            @(posedge clk_100);
            #1;
            if (!reset_n) begin
                pend_q.delete();
                a_ready = 1'b0;
                d_valid = 1'b0;
            end else begin
                if (slv_a_fire) begin
                    pend_q.push_back(slv_a_req);
                    if (rdy_limit > 0) rdy_limit--;
                end
                if (slv_d_fire) begin
                    d_valid = 1'b0;
                    void'(pend_q.pop_front());
                end
                a_ready = (rdy_limit != 0) && chance(rdy_prob);
                if (!d_valid && !hold_d && (pend_q.size() > 0) && chance(d_prob)) begin
                    r = pend_q[0];
                    d_source = r.src;
                    d_error = chance(err_prob);
                    opbad = chance(opbad_prob);
                    bad = d_error || opbad;
                    if (r.op == 3'd0) begin
                        d_opcode = opbad ? 3'd1 : 3'd0;
                        d_data = $urandom;
                    end else begin
                        d_opcode = opbad ? 3'd0 : 3'd1;
                        cd = (run_mode == 2) ? r.data : $urandom;
                        if (corrupt_src2 && (r.src == 2'd2)) begin
                            d_data = '0;
                            if ((run_mode == 2) && (cd != '0)) bad = 1;
                        end else if (chance(corr_prob)) begin
                            d_data = ~cd;
                            if (run_mode == 2) bad = 1;
                        end else begin
                            d_data = cd;
                        end
                    end
                    if (bad) exp_err++;
                    d_valid = 1'b1;
                end
            end
        end
    end

    task automatic start_run(input int mode, input int num, input logic [AW-1:0] base,
                             input logic [DW-1:0] seed);
        int eff;
        req_t r;
        eff = (mode == 3) ? 0 : mode;
        run_mode = eff;
        exp_err = 0;
        fires = 0;
        if (eff != 1) begin
            for (int i = 0; i < num; i++) begin
                r.op = 3'd0; r.src = SW'(i % MO); r.addr = base + AW'(i * MW); r.data = seed + DW'(i);
                exp_q.push_back(r);
            end
        end
        if (eff != 0) begin
            for (int i = 0; i < num; i++) begin
                r.op = 3'd4; r.src = SW'(i % MO); r.addr = base + AW'(i * MW); r.data = seed + DW'(i);
                exp_q.push_back(r);
            end
        end
        @(posedge clk_100);
        #1;
        run_dc0 = done_cnt;
        cfg_mode = 2'(mode); cfg_base = base; cfg_num = CW'(num); cfg_seed = seed;
        start = 1'b1;
        @(posedge clk_100);
        #1;
        start = 1'b0;
        in_run = 1;
        cfg_mode = 2'($urandom); cfg_base = $urandom; cfg_num = CW'($urandom); cfg_seed = $urandom;
    endtask

    task automatic finish_run(input string name, input int total, input int budget);
        int n;
        n = 0;
        while ((done_cnt == run_dc0) && (n < budget)) begin
            @(posedge clk_100);
            n++;
        end
        if (done_cnt == run_dc0) begin
            chk({name, "_done_timeout"}, 64'(0), 64'(1));
            summary_and_finish();
        end
        repeat (3) @(posedge clk_100);
        #2;
        chk({name, "_done_pulses"}, 64'(done_cnt - run_dc0), 64'(1));
        chk({name, "_err_count"}, 64'(err_count), 64'((exp_err > 255) ? 255 : exp_err));
        chk({name, "_issued"}, 64'(issued), 64'(total % 65536));
        chk({name, "_a_fires"}, 64'(fires), 64'(total));
        chk({name, "_exp_queue_empty"}, 64'(exp_q.size()), 64'(0));
    endtask

    task automatic knobs_default();
        rdy_prob = 100; rdy_limit = -1; d_prob = 100; err_prob = 0; corr_prob = 0; opbad_prob = 0;
        hold_d = 0; corrupt_src2 = 0;
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int n, lat, dc, mode, num;
        logic [AW-1:0] base;
        logic [DW-1:0] seed;

        repeat (3) @(posedge clk_100);
        @(negedge clk_100);
        chk("rst_a_valid", 64'(a_valid), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_err_count", 64'(err_count), 64'(0));
        chk("rst_issued", 64'(issued), 64'(0));
        chk("rst_a_fields", 64'({a_opcode, a_param, a_size, a_source, a_mask}), 64'(0));
        chk("rst_a_addr_data", {a_address, a_data}, 64'(0));
        @(posedge clk_100);
        #3;
        reset_n = 1'b1;

        // Directed write-then-readback with a well-behaved slave.
        start_run(2, 4, 32'h1000, 32'hDEADBEEF);
        finish_run("wr_rd_ok", 8, 400);

        // Same, but the slave returns zero for source 2 on readback.
        corrupt_src2 = 1;
        start_run(2, 4, 32'h1000, 32'hDEADBEEF);
        finish_run("wr_rd_src2_bad", 8, 400);
        knobs_default();

        // Outstanding limit: responses withheld, only MAX_OUT requests may go out.
        hold_d = 1;
        start_run(1, 8, 32'h0000_4000, 32'h1234_0000);
        repeat (20) @(posedge clk_100);
        #2;
        chk("hold_fires", 64'(fires), 64'(4));
        @(negedge clk_100);
        chk("hold_a_valid_low", 64'(a_valid), 64'(0));
        cfg_mode = 2'd0; cfg_num = CW'(5); start = 1'b1;
        @(posedge clk_100);
        #1;
        start = 1'b0;
        hold_d = 0;
        finish_run("hold_release", 8, 400);

        // Back-pressure: request must stay put while a_ready is low and fire once it rises.
        rdy_prob = 0;
        start_run(0, 3, 32'h0000_2000, 32'h0000_0055);
        n = 0;
        while (!a_valid && (n < 20)) begin
            @(negedge clk_100);
            n++;
        end
        chk("stall_a_valid_seen", 64'(a_valid), 64'(1));
        repeat (5) @(negedge clk_100);
        chk("stall_no_fire", 64'(fires), 64'(0));
        chk("stall_a_valid_held", 64'(a_valid), 64'(1));
        rdy_prob = 100;
        @(posedge clk_100);
        #2;
        chk("stall_ready_rises", 64'(a_ready), 64'(1));
        @(posedge clk_100);
        #2;
        chk("stall_fire_on_ready", 64'(fires), 64'(1));
        finish_run("stall", 3, 400);

        // Zero-length run: straight to FIN, no A traffic.
        start_run(0, 0, 32'h0, 32'h0);
        lat = 1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_100);
            if (done) break;
            lat++;
        end
        chk("num0_done_latency", 64'(lat), 64'(2));
        finish_run("num0", 0, 20);

        // Reset during the read phase with two requests outstanding.
        hold_d = 1;
        rdy_limit = 2;
        start_run(1, 8, 32'h0000_8000, 32'h0);
        n = 0;
        while ((fires < 2) && (n < 50)) begin
            @(posedge clk_100);
            n++;
        end
        repeat (2) @(posedge clk_100);
        #2;
        chk("rst_mid_two_out", 64'(model_out), 64'(2));
        #1;
        reset_n = 1'b0;
        in_run = 0;
        #1;
        chk("rst_mid_busy", 64'(busy), 64'(0));
        chk("rst_mid_d_ready", 64'(d_ready), 64'(0));
        chk("rst_mid_a_valid", 64'(a_valid), 64'(0));
        chk("rst_mid_issued", 64'(issued), 64'(0));
        exp_q.delete();
        model_out = 0;
        repeat (2) @(posedge clk_100);
        #3;
        reset_n = 1'b1;
        knobs_default();
        dc = done_cnt;
        repeat (10) @(posedge clk_100);
        #2;
        chk("rst_mid_no_done", 64'(done_cnt - dc), 64'(0));
        start_run(2, 4, 32'h1000, 32'hDEADBEEF);
        finish_run("after_reset", 8, 400);

        // Error counter saturation.
        err_prob = 100;
        start_run(0, 300, 32'h0010_0000, 32'h0);
        finish_run("saturate", 300, 4000);
        knobs_default();

        // Randomized runs, including address/data wrap-around and mode 3.
        for (int run = 0; run < 10; run++) begin
            mode = int'($urandom_range(3));
            num  = int'($urandom_range(20, 1));
            base = (run % 3 == 0) ? 32'hFFFF_FFF0 : $urandom;
            seed = (run % 4 == 1) ? 32'hFFFF_FFFE : $urandom;
            rdy_prob   = int'($urandom_range(100, 30));
            d_prob     = int'($urandom_range(100, 20));
            err_prob   = int'($urandom_range(15));
            corr_prob  = int'($urandom_range(30));
            opbad_prob = int'($urandom_range(10));
            start_run(mode, num, base, seed);
            finish_run($sformatf("rand%0d", run), (mode == 2) ? 2 * num : num, 2000);
            knobs_default();
        end

        summary_and_finish();
    end
endmodule
